// File: rtl/mmio_port_responder_if.sv
// rtl/mmio_port_responder_if.sv - MEM-stage data bus between the core and the MMIO responder
interface mmio_port_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ReadData;
  logic        Hit;

  modport master (output Address, WriteData, MemWrite, MemRead, input ReadData, Hit);
  modport slave  (input Address, WriteData, MemWrite, MemRead, output ReadData, Hit);
endinterface

// File: rtl/mmio_port_responder.sv
// rtl/mmio_port_responder.sv - MMIO responder: output port, synchronized input port, timer/compare, irq
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
  parameter int          IN_WIDTH    = 8,
  parameter int          TIMER_WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  mmio_port_responder_if.slave bus,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Irq
);
  localparam logic [2:0] OFS_PORT_OUT = 3'd0;
  localparam logic [2:0] OFS_PORT_IN  = 3'd1;
  localparam logic [2:0] OFS_STATUS   = 3'd2;
  localparam logic [2:0] OFS_CAPTURE  = 3'd3;
  localparam logic [2:0] OFS_TIMER    = 3'd4;
  localparam logic [2:0] OFS_COMPARE  = 3'd5;
  localparam logic [2:0] OFS_CTRL     = 3'd6;

  logic [IN_WIDTH-1:0]    sync1;
  logic [IN_WIDTH-1:0]    sync2;
  logic [IN_WIDTH-1:0]    prevIn;
  logic [IN_WIDTH-1:0]    capture;
  logic [1:0]             status;
  logic [TIMER_WIDTH-1:0] timer;
  logic [TIMER_WIDTH-1:0] compare;
  logic [2:0]             ctrl;

  logic [2:0]  wordOfs;
  logic        winHit;
  logic        readHit;
  logic        writeHit;
  logic        inChange;
  logic        tmrMatch;
  logic        timerWrite;
  logic [1:0]  statusClr;
  logic [31:0] readMux;
  logic        unusedAddrBits;

  assign wordOfs        = bus.Address[4:2];
  assign winHit         = (bus.Address[31:5] == BASE_ADDR[31:5]);
  assign bus.Hit        = (bus.MemRead | bus.MemWrite) & winHit;
  assign readHit        = bus.MemRead & winHit;
  assign writeHit       = bus.MemWrite & winHit;
  assign unusedAddrBits = ^bus.Address[1:0];

  // Change detection and match both look at pre-edge values; a same-edge W1C never hides them.
  assign inChange   = (sync2 != prevIn);
  assign tmrMatch   = ctrl[0] & (timer == compare);
  assign timerWrite = writeHit && (wordOfs == OFS_TIMER);
  assign statusClr  = (writeHit && (wordOfs == OFS_STATUS)) ? bus.WriteData[1:0] : 2'b00;

  always_comb begin
    readMux = '0;
    case (wordOfs)
      OFS_PORT_OUT: readMux = PortOut;
      OFS_PORT_IN:  readMux = 32'(sync2);
      OFS_STATUS:   readMux = {30'd0, status};
      OFS_CAPTURE:  readMux = 32'(capture);
      OFS_TIMER:    readMux = 32'(timer);
      OFS_COMPARE:  readMux = 32'(compare);
      OFS_CTRL:     readMux = {29'd0, ctrl};
      default:      readMux = '0;
    endcase
  end

  assign bus.ReadData = readHit ? readMux : 32'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= '0;
      sync2   <= '0;
      prevIn  <= '0;
      capture <= '0;
      status  <= '0;
      timer   <= '0;
      compare <= '0;
      ctrl    <= '0;
      PortOut <= '0;
    end else begin
      sync1  <= PortIn;
      sync2  <= sync1;
      prevIn <= sync2;
      if (inChange) begin
        capture <= sync2;
      end
      status <= (status & ~statusClr) | {tmrMatch, inChange};

      if (writeHit) begin
        case (wordOfs)
          OFS_PORT_OUT: PortOut <= bus.WriteData;
          OFS_COMPARE:  compare <= bus.WriteData[TIMER_WIDTH-1:0];
          OFS_CTRL:     ctrl    <= bus.WriteData[2:0];
          default:      ;
        endcase
      end

      if (timerWrite) begin
        timer <= bus.WriteData[TIMER_WIDTH-1:0];
      end else if (ctrl[0]) begin
        timer <= timer + TIMER_WIDTH'(1);
      end
    end
  end

  assign Irq = |(status & ctrl[2:1]);
endmodule

// File: tb/tb_mmio_port_responder.sv
// tb/tb_mmio_port_responder.sv - directed and randomized checks of mmio_port_responder against a reference model
module tb_mmio_port_responder;
  localparam logic [31:0] BASE = 32'h1001_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  PortIn = 8'd0;
  logic [31:0] PortOut;
  logic        Irq;

  mmio_port_responder_if bus ();

  mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8), .TIMER_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .bus(bus), .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
  );

  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference state. pinHist[0] is the PortIn value sampled at the latest edge, [1] one edge before, etc.
  logic [31:0] mPortOut, mTimer, mCompare;
  logic [7:0]  mCapture;
  logic [1:0]  mStatus;
  logic [2:0]  mCtrl;
  logic [7:0]  pinHist [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mPortOut = 0; mTimer = 0; mCompare = 0; mCapture = 0; mStatus = 0; mCtrl = 0;
    for (int i = 0; i < 3; i++) pinHist[i] = 8'd0;
  endfunction

  // Register visible to software: the input register shows the value that crossed two flops.
  function automatic logic [31:0] modelRead(input logic [2:0] ofs);
    case (ofs)
      3'd0: return mPortOut;
      3'd1: return {24'd0, pinHist[1]};
      3'd2: return {30'd0, mStatus};
      3'd3: return {24'd0, mCapture};
      3'd4: return mTimer;
      3'd5: return mCompare;
      3'd6: return {29'd0, mCtrl};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void modelEdge(input logic we, input logic [2:0] ofs, input logic [31:0] wd,
                                    input logic [7:0] pin);
    logic chg, match;
    logic [1:0] clr;
    chg   = (pinHist[1] != pinHist[2]);
    match = mCtrl[0] && (mTimer == mCompare);
    clr   = (we && ofs == 3'd2) ? wd[1:0] : 2'b00;
    if (chg) mCapture = pinHist[1];
    mStatus = (mStatus & ~clr) | {match, chg};
    if (we && ofs == 3'd4)      mTimer = wd;
    else if (mCtrl[0])          mTimer = mTimer + 32'd1;
    if (we && ofs == 3'd0) mPortOut = wd;
    if (we && ofs == 3'd5) mCompare = wd;
    if (we && ofs == 3'd6) mCtrl = wd[2:0];
    pinHist[2] = pinHist[1];
    pinHist[1] = pinHist[0];
    pinHist[0] = pin;
  endfunction

  task automatic cycle(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [7:0] pin, output logic [31:0] rdObs);
    logic inWin;
    @(negedge clk);
    bus.MemRead = rd; bus.MemWrite = wr; bus.Address = addr; bus.WriteData = wd; PortIn = pin;
    #1;
    inWin = (addr[31:5] == BASE[31:5]);
    rdObs = bus.ReadData;
    chk("hit", {31'd0, bus.Hit}, {31'd0, (rd | wr) & inWin});
    chk("read_data", bus.ReadData, (rd && inWin) ? modelRead(addr[4:2]) : 32'd0);
    chk("irq_pre", {31'd0, Irq}, {31'd0, |(mStatus & mCtrl[2:1])});
    @(posedge clk);
    modelEdge(wr && inWin, addr[4:2], wd, pin);
    #1;
    chk("port_out", PortOut, mPortOut);
    chk("irq_post", {31'd0, Irq}, {31'd0, |(mStatus & mCtrl[2:1])});
  endtask

  logic [31:0] rd;
  logic [7:0]  pin;

  initial begin
    bus.MemRead = 0; bus.MemWrite = 0; bus.Address = 0; bus.WriteData = 0;
    modelReset();
    pin = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_port_out", PortOut, 32'd0);
    chk("reset_irq", {31'd0, Irq}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Output port store then load
    cycle(0, 1, BASE + 32'h00, 32'hA5A5_0001, pin, rd);
    chk("t1_port_out", PortOut, 32'hA5A5_0001);
    cycle(1, 0, BASE + 32'h03, 32'd0, pin, rd);
    chk("t1_load", rd, 32'hA5A5_0001);

    // Input change takes three edges to reach STATUS
    pin = 8'h3C;
    cycle(0, 0, 32'd0, 32'd0, pin, rd);
    cycle(0, 0, 32'd0, 32'd0, pin, rd);
    cycle(1, 0, BASE + 32'h08, 32'd0, pin, rd);
    chk("t2_not_yet", rd, 32'd0);
    cycle(1, 0, BASE + 32'h08, 32'd0, pin, rd);
    chk("t2_in_chg", rd, 32'd1);
    cycle(1, 0, BASE + 32'h0C, 32'd0, pin, rd);
    chk("t2_capture", rd, 32'h3C);
    cycle(0, 1, BASE + 32'h08, 32'd1, pin, rd);
    cycle(1, 0, BASE + 32'h08, 32'd0, pin, rd);
    chk("t2_cleared", rd, 32'd0);

    // Timer compare and interrupt
    cycle(0, 1, BASE + 32'h14, 32'd10, pin, rd);
    cycle(0, 1, BASE + 32'h10, 32'd0, pin, rd);
    cycle(0, 1, BASE + 32'h18, 32'd5, pin, rd);
    repeat (10) cycle(0, 0, 32'd0, 32'd0, pin, rd);
    chk("t3_irq_before", {31'd0, Irq}, 32'd0);
    cycle(0, 0, 32'd0, 32'd0, pin, rd);
    chk("t3_irq_set", {31'd0, Irq}, 32'd1);
    cycle(1, 0, BASE + 32'h08, 32'd0, pin, rd);
    chk("t3_match_flag", rd, 32'd2);
    cycle(0, 1, BASE + 32'h08, 32'd2, pin, rd);
    chk("t3_irq_cleared", {31'd0, Irq}, 32'd0);

    // Timer wrap raises no flag
    cycle(0, 1, BASE + 32'h10, 32'hFFFF_FFFF, pin, rd);
    cycle(1, 0, BASE + 32'h10, 32'd0, pin, rd);
    chk("t4_timer_max", rd, 32'hFFFF_FFFF);
    cycle(1, 0, BASE + 32'h10, 32'd0, pin, rd);
    chk("t4_timer_wrap", rd, 32'd0);
    cycle(1, 0, BASE + 32'h08, 32'd0, pin, rd);
    chk("t4_no_flag", rd, 32'd0);

    // A new change on the clearing edge keeps in_chg set
    pin = 8'h55;
    repeat (3) cycle(0, 0, 32'd0, 32'd0, pin, rd);
    pin = 8'h66;
    repeat (2) cycle(0, 0, 32'd0, 32'd0, pin, rd);
    cycle(0, 1, BASE + 32'h08, 32'd1, pin, rd);
    cycle(1, 0, BASE + 32'h08, 32'd0, pin, rd);
    chk("t5_set_wins", rd & 32'd1, 32'd1);
    cycle(1, 0, BASE + 32'h0C, 32'd0, pin, rd);
    chk("t5_capture", rd, 32'h66);
    cycle(1, 0, BASE + 32'h1C, 32'd0, pin, rd);
    chk("t5_reserved", rd, 32'd0);
    cycle(1, 0, 32'h2000_0008, 32'd0, pin, rd);
    chk("t5_outside_hit", {31'd0, bus.Hit}, 32'd0);
    chk("t5_outside_data", rd, 32'd0);

    // Asynchronous reset between edges
    cycle(0, 1, BASE + 32'h18, 32'd3, pin, rd);
    chk("t6_irq_armed", {31'd0, Irq}, 32'd1);
    @(negedge clk);
    bus.MemRead = 1; bus.MemWrite = 0; bus.Address = BASE + 32'h10;
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    chk("t6_port_out", PortOut, 32'd0);
    chk("t6_irq", {31'd0, Irq}, 32'd0);
    chk("t6_timer", bus.ReadData, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [31:0] addr, wd;
      logic        r, w;
      logic [2:0]  ofs;
      ofs  = 3'($urandom_range(0, 7));
      addr = BASE + {27'd0, ofs, 2'b00} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        addr = $urandom;
        if (addr[31:5] == BASE[31:5]) addr[31] = ~addr[31];
      end
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (ofs == 3'd5 && $urandom_range(0, 1) == 1) wd = mTimer + 32'($urandom_range(0, 6));
      if (ofs == 3'd6 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      if ($urandom_range(0, 5) == 0) pin = 8'($urandom);
      cycle(r, w, addr, wd, pin, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end
endmodule
